// File: rtl/rv32im_muldiv_unit_pkg.sv
// Shared definitions for the RV32IM multiply/divide unit: datapath width,
// FSM state encoding, operand-signedness and result-select encodings.
package rv32im_muldiv_unit_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // sn[1] = rs1 signed, sn[0] = rs2 signed
  localparam logic [1:0] SN_SS = 2'b11;
  localparam logic [1:0] SN_SU = 2'b10;
  localparam logic [1:0] SN_UU = 2'b00;

  // m_sel[1] = multiply class, m_sel[0] = high word / remainder
  localparam logic [1:0] MSEL_MUL  = 2'b10;
  localparam logic [1:0] MSEL_MULH = 2'b11;
  localparam logic [1:0] MSEL_DIV  = 2'b00;
  localparam logic [1:0] MSEL_REM  = 2'b01;

  // Two's-complement negate when neg is set, pass-through otherwise.
  function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/rv32im_muldiv_unit_if.sv
// Request/response bundle between a pipeline and the multiply/divide unit.
interface rv32im_muldiv_unit_if;
  import rv32im_muldiv_unit_pkg::*;

  logic            start;
  logic            mul_en;
  logic            div_en;
  logic [1:0]      sn;
  logic [1:0]      m_sel;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic            flush;
  logic [XLEN-1:0] result;
  logic            busy;
  logic            done;

  modport master (
    output start, mul_en, div_en, sn, m_sel, rs1, rs2, flush,
    input  result, busy, done
  );

  modport slave (
    input  start, mul_en, div_en, sn, m_sel, rs1, rs2, flush,
    output result, busy, done
  );
endinterface

// File: rtl/rv32im_div_core.sv
// Restoring unsigned divider: one quotient bit per cycle, 32 cycles.
// quo_o/rem_o present the value after the current iteration so the parent
// can capture the final result on the same edge that done_o is high.
module rv32im_div_core
  import rv32im_muldiv_unit_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic            flush_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] quo_o,
  output logic [XLEN-1:0] rem_o,
  output logic            done_o
);

  logic            busy_q;
  logic [4:0]      cnt_q;
  logic [XLEN-1:0] quo_q;
  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] dvs_q;
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   diff;
  logic            take;

  // One restoring step: shift in next dividend bit, subtract if it fits.
  always_comb begin
    shifted = {rem_q, quo_q[XLEN-1]};
    diff    = shifted - {1'b0, dvs_q};
    take    = ~diff[XLEN];
    rem_o   = take ? diff[XLEN-1:0] : shifted[XLEN-1:0];
    quo_o   = {quo_q[XLEN-2:0], take};
    done_o  = busy_q && (cnt_q == 5'd31);
  end

  // Iteration registers; the dividend shifts out of quo_q as quotient bits shift in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      quo_q  <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
    end else if (flush_i) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else if (start_i) begin
      busy_q <= 1'b1;
      cnt_q  <= '0;
      quo_q  <= dividend_i;
      rem_q  <= '0;
      dvs_q  <= divisor_i;
    end else if (busy_q) begin
      quo_q <= quo_o;
      rem_q <= rem_o;
      cnt_q <= cnt_q + 5'd1;
      if (cnt_q == 5'd31) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/rv32im_muldiv_unit.sv
// RV32IM M-extension execution unit: single-cycle multiply, 32-cycle
// restoring divide with the divide-by-zero and signed-overflow cases
// resolved immediately at acceptance.
module rv32im_muldiv_unit #(
  parameter int XLEN = 32
) (
  input logic               clk,
  input logic               rst_n,
  rv32im_muldiv_unit_if.slave bus
);
  import rv32im_muldiv_unit_pkg::*;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   a_q, a_d, b_q, b_d, result_q, result_d;
  logic [1:0]        sn_q, sn_d;
  logic              hi_q, hi_d, negq_q, negq_d, negr_q, negr_d;
  logic              accept, neg_a, neg_b, div_zero, div_ovf, div_start;
  logic [XLEN-1:0]   mag_a, mag_b, dc_quo, dc_rem;
  logic              dc_done;
  logic [2*XLEN-1:0] ax, bx, prod;
  logic              unused_msel;

  // m_sel[1] duplicates mul_en; the class is taken from the enables.
  assign unused_msel = bus.m_sel[1];

  // Operand extension per signedness, divide magnitudes and special cases.
  always_comb begin
    ax       = {{XLEN{sn_q[1] & a_q[XLEN-1]}}, a_q};
    bx       = {{XLEN{sn_q[0] & b_q[XLEN-1]}}, b_q};
    prod     = ax * bx;
    neg_a    = bus.sn[1] & bus.rs1[XLEN-1];
    neg_b    = bus.sn[0] & bus.rs2[XLEN-1];
    mag_a    = cond_neg(bus.rs1, neg_a);
    mag_b    = cond_neg(bus.rs2, neg_b);
    div_zero = (bus.rs2 == '0);
    div_ovf  = (bus.sn == SN_SS) && (bus.rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (bus.rs2 == '1);
    accept   = bus.start && !bus.flush && (bus.mul_en ^ bus.div_en) &&
               ((state_q == ST_IDLE) || (state_q == ST_DONE));
  end

  // Next-state, operand capture and result selection.
  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    a_d       = a_q;
    b_d       = b_q;
    sn_d      = sn_q;
    hi_d      = hi_q;
    negq_d    = negq_q;
    negr_d    = negr_q;
    div_start = 1'b0;
    case (state_q)
      ST_MUL: begin
        state_d  = ST_DONE;
        result_d = hi_q ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
      end
      ST_DIV: begin
        if (dc_done) begin
          state_d  = ST_DONE;
          result_d = hi_q ? cond_neg(dc_rem, negr_q) : cond_neg(dc_quo, negq_q);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: ;
    endcase
    if (accept) begin
      a_d    = bus.rs1;
      b_d    = bus.rs2;
      sn_d   = bus.sn;
      hi_d   = bus.m_sel[0];
      negq_d = neg_a ^ neg_b;
      negr_d = neg_a;
      if (bus.mul_en) begin
        state_d = ST_MUL;
      end else if (div_zero) begin
        state_d  = ST_DONE;
        result_d = bus.m_sel[0] ? bus.rs1 : '1;
      end else if (div_ovf) begin
        state_d  = ST_DONE;
        result_d = bus.m_sel[0] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
      end else begin
        state_d   = ST_DIV;
        div_start = 1'b1;
      end
    end
    if (bus.flush) begin
      state_d  = ST_IDLE;
      result_d = result_q;
    end
  end

  // State, result and captured-operand registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      a_q      <= '0;
      b_q      <= '0;
      sn_q     <= '0;
      hi_q     <= 1'b0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sn_q     <= sn_d;
      hi_q     <= hi_d;
      negq_q   <= negq_d;
      negr_q   <= negr_d;
    end
  end

  rv32im_div_core u_div_core (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (div_start),
    .flush_i    (bus.flush),
    .dividend_i (mag_a),
    .divisor_i  (mag_b),
    .quo_o      (dc_quo),
    .rem_o      (dc_rem),
    .done_o     (dc_done)
  );

  assign bus.result = result_q;
  assign bus.busy   = (state_q == ST_MUL) || (state_q == ST_DIV);
  assign bus.done   = (state_q == ST_DONE);

endmodule
